// File: rtl/target_report_sched.sv
// Purpose: frame-boundary snapshot of the detector target table, detector clear pulse, then per-slot serial report.
// Latency: vsync at edge k -> det_clear_out during cycle k+1 -> first beat valid from cycle k+2; back-to-back beats, no bubbles.
// Backpressure: rpt_* registers hold while rpt_valid_out & !rpt_ready_in; a vsync during a report is dropped and flagged on overrun_out.
// Build option: define TARGET_AGEING_EN to keep missing targets alive (stale, last coords) for up to MAX_MISS frames.
module target_report_sched #(
    parameter int NUM_TARGETS = 4,
    parameter int COORD_W     = 11,
    parameter int MAX_MISS    = 3,
    localparam int IDX_W      = $clog2(NUM_TARGETS)
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               vsync_in,
    input  logic [COORD_W-1:0] tgt_hcount_in   [NUM_TARGETS],
    input  logic [COORD_W-1:0] tgt_vcount_in   [NUM_TARGETS],
    input  logic [COORD_W-1:0] tgt_diameter_in [NUM_TARGETS],
    input  logic               tgt_valid_in    [NUM_TARGETS],
    output logic               det_clear_out,
    output logic               rpt_valid_out,
    input  logic               rpt_ready_in,
    output logic [IDX_W-1:0]   rpt_index_out,
    output logic [COORD_W-1:0] rpt_hcount_out,
    output logic [COORD_W-1:0] rpt_vcount_out,
    output logic [COORD_W-1:0] rpt_diameter_out,
    output logic               rpt_live_out,
    output logic               rpt_stale_out,
    output logic               rpt_last_out,
    output logic [15:0]        frame_count_out,
    output logic               overrun_out
);

    typedef struct packed {
        logic [COORD_W-1:0] hcount;
        logic [COORD_W-1:0] vcount;
        logic [COORD_W-1:0] diameter;
    } tgt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SEND
    } state_t;

    // Unsupported parameter sets are rejected at elaboration.
    if (NUM_TARGETS < 2 || MAX_MISS < 1 || MAX_MISS > 15) begin : g_param_check
        $error("target_report_sched: NUM_TARGETS must be >= 2 and MAX_MISS in 1..15");
    end

    state_t                 state_q, state_nxt;
    tgt_t                   shadow_q   [NUM_TARGETS];
    tgt_t                   shadow_nxt [NUM_TARGETS];
    logic [NUM_TARGETS-1:0] live_q, live_nxt;
    logic [NUM_TARGETS-1:0] stale_q, stale_nxt;
    logic [IDX_W-1:0]       ptr_q;
    logic [IDX_W-1:0]       first_nxt;
    logic [IDX_W-1:0]       above_ptr;
    logic [IDX_W-1:0]       load_idx;
    logic                   load_has_above;
    logic                   snap_en;
    logic                   load_en;
    logic                   hs;

`ifdef TARGET_AGEING_EN
    localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISS);
    logic [3:0] miss_q   [NUM_TARGETS];
    logic [3:0] miss_nxt [NUM_TARGETS];
`endif

    // Lowest set slot at or above lo (0 when none).
    function automatic logic [IDX_W-1:0] first_live_from(input logic [NUM_TARGETS-1:0] mask, input int lo);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (i >= lo && mask[i]) begin
                res = IDX_W'(i);
            end
        end
        return res;
    endfunction

    // True when any slot at or above lo is set.
    function automatic logic has_live_from(input logic [NUM_TARGETS-1:0] mask, input int lo);
        logic res;
        res = 1'b0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            if (i >= lo && mask[i]) begin
                res = 1'b1;
            end
        end
        return res;
    endfunction

    assign hs             = rpt_valid_out && rpt_ready_in;
    assign first_nxt      = first_live_from(live_nxt, 0);
    assign above_ptr      = first_live_from(live_q, int'(ptr_q) + 1);
    assign load_has_above = has_live_from(live_q, int'(load_idx) + 1);

    // Table contents the next snapshot would capture, including miss ageing.
    always_comb begin
        for (int i = 0; i < NUM_TARGETS; i++) begin
            shadow_nxt[i] = shadow_q[i];
            live_nxt[i]   = live_q[i];
            stale_nxt[i]  = stale_q[i];
`ifdef TARGET_AGEING_EN
            miss_nxt[i] = miss_q[i];
            if (tgt_valid_in[i]) begin
                shadow_nxt[i] = {tgt_hcount_in[i], tgt_vcount_in[i], tgt_diameter_in[i]};
                live_nxt[i]   = 1'b1;
                stale_nxt[i]  = 1'b0;
                miss_nxt[i]   = 4'd0;
            end else if (live_q[i]) begin
                miss_nxt[i]  = miss_q[i] + 4'd1;
                stale_nxt[i] = 1'b1;
                if ((miss_q[i] + 4'd1) == MISS_LIMIT) begin
                    live_nxt[i] = 1'b0;
                end
            end
`else
            live_nxt[i]  = tgt_valid_in[i];
            stale_nxt[i] = 1'b0;
            if (tgt_valid_in[i]) begin
                shadow_nxt[i] = {tgt_hcount_in[i], tgt_vcount_in[i], tgt_diameter_in[i]};
            end
`endif
        end
    end

    // Frame sequencing: snapshot on vsync in IDLE, one clear cycle, then stream until the last beat is taken.
    always_comb begin
        state_nxt = state_q;
        snap_en   = 1'b0;
        load_en   = 1'b0;
        load_idx  = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (vsync_in) begin
                    state_nxt = ST_CLEAR;
                    snap_en   = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_SEND;
                load_en   = 1'b1;
                load_idx  = ptr_q;
            end
            ST_SEND: begin
                if (hs) begin
                    if (rpt_last_out) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        load_en  = 1'b1;
                        load_idx = above_ptr;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Shadow table, live/stale masks and report pointer.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                shadow_q[i] <= '0;
            end
            live_q  <= '0;
            stale_q <= '0;
            ptr_q   <= '0;
        end else if (snap_en) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                shadow_q[i] <= shadow_nxt[i];
            end
            live_q  <= live_nxt;
            stale_q <= stale_nxt;
            ptr_q   <= first_nxt;
        end else if (load_en) begin
            ptr_q <= load_idx;
        end
    end

`ifdef TARGET_AGEING_EN
    // Consecutive-miss counters, advanced only at snapshot.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                miss_q[i] <= 4'd0;
            end
        end else if (snap_en) begin
            for (int i = 0; i < NUM_TARGETS; i++) begin
                miss_q[i] <= miss_nxt[i];
            end
        end
    end
`endif

    // Report beat registers: loaded on entry to SEND and on each non-final handshake.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rpt_valid_out    <= 1'b0;
            rpt_index_out    <= '0;
            rpt_hcount_out   <= '0;
            rpt_vcount_out   <= '0;
            rpt_diameter_out <= '0;
            rpt_live_out     <= 1'b0;
            rpt_stale_out    <= 1'b0;
            rpt_last_out     <= 1'b0;
        end else if (load_en) begin
            rpt_valid_out <= 1'b1;
            if (live_q == '0) begin
                // Empty frame still produces one null beat so the consumer sees every frame.
                rpt_index_out    <= '0;
                rpt_hcount_out   <= '0;
                rpt_vcount_out   <= '0;
                rpt_diameter_out <= '0;
                rpt_live_out     <= 1'b0;
                rpt_stale_out    <= 1'b0;
                rpt_last_out     <= 1'b1;
            end else begin
                rpt_index_out    <= load_idx;
                rpt_hcount_out   <= shadow_q[load_idx].hcount;
                rpt_vcount_out   <= shadow_q[load_idx].vcount;
                rpt_diameter_out <= shadow_q[load_idx].diameter;
                rpt_live_out     <= 1'b1;
                rpt_stale_out    <= stale_q[load_idx];
                rpt_last_out     <= !load_has_above;
            end
        end else if (hs && rpt_last_out) begin
            rpt_valid_out <= 1'b0;
        end
    end

    // Detector clear: one cycle after an accepted frame boundary.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            det_clear_out <= 1'b0;
        end else begin
            det_clear_out <= snap_en;
        end
    end

    // Frame counter and sticky overrun flag.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            frame_count_out <= 16'd0;
            overrun_out     <= 1'b0;
        end else if (vsync_in) begin
            frame_count_out <= frame_count_out + 16'd1;
            if (state_q != ST_IDLE) begin
                overrun_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_target_report_sched.sv
// Bench for target_report_sched: stimulus pushes expected beats from a frame-level model,
// a negedge monitor pops and compares them on every valid cycle.
module tb_target_report_sched;

    localparam int NT = 4;
    localparam int CW = 11;
    localparam int MM = 3;

    logic          clk_in       = 1'b0;
    logic          rst_n_in     = 1'b0;
    logic          vsync_in     = 1'b0;
    logic          rpt_ready_in = 1'b0;
    logic [CW-1:0] hc [NT];
    logic [CW-1:0] vc [NT];
    logic [CW-1:0] dm [NT];
    logic          vl [NT];

    logic          det_clear_out;
    logic          rpt_valid_out;
    logic [1:0]    rpt_index_out;
    logic [CW-1:0] rpt_hcount_out;
    logic [CW-1:0] rpt_vcount_out;
    logic [CW-1:0] rpt_diameter_out;
    logic          rpt_live_out;
    logic          rpt_stale_out;
    logic          rpt_last_out;
    logic [15:0]   frame_count_out;
    logic          overrun_out;

    target_report_sched #(.NUM_TARGETS(NT), .COORD_W(CW), .MAX_MISS(MM)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .vsync_in(vsync_in),
        .tgt_hcount_in(hc), .tgt_vcount_in(vc), .tgt_diameter_in(dm), .tgt_valid_in(vl),
        .det_clear_out(det_clear_out), .rpt_valid_out(rpt_valid_out), .rpt_ready_in(rpt_ready_in),
        .rpt_index_out(rpt_index_out), .rpt_hcount_out(rpt_hcount_out), .rpt_vcount_out(rpt_vcount_out),
        .rpt_diameter_out(rpt_diameter_out), .rpt_live_out(rpt_live_out), .rpt_stale_out(rpt_stale_out),
        .rpt_last_out(rpt_last_out), .frame_count_out(frame_count_out), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int            idx;
        logic          live;
        logic          stale;
        logic          last;
        logic [CW-1:0] h;
        logic [CW-1:0] v;
        logic [CW-1:0] d;
        int            t;
    } beat_t;

    beat_t exp_q[$];
    int    clr_q[$];
    int    checks  = 0;
    int    errors  = 0;
    int    cyc     = 0;
    bit    mon_en  = 0;
    int    rdy_mode = 2;
    int    exp_frame = 0;
    bit    exp_ovr   = 0;

    // Frame-level reference table.
    bit            m_live  [NT];
    int            m_miss  [NT];
    bit            m_stale [NT];
    logic [CW-1:0] m_h [NT];
    logic [CW-1:0] m_v [NT];
    logic [CW-1:0] m_d [NT];

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NT; i++) begin
            m_live[i] = 0; m_miss[i] = 0; m_stale[i] = 0;
            m_h[i] = '0; m_v[i] = '0; m_d[i] = '0;
        end
        exp_frame = 0;
        exp_ovr   = 0;
    endfunction

    // Apply the frame rules to the table and queue the beats that frame must produce.
    function automatic void model_snapshot(input int first_t);
        int    lst[$];
        beat_t b;
        for (int i = 0; i < NT; i++) begin
`ifdef TARGET_AGEING_EN
            if (vl[i]) begin
                m_live[i] = 1; m_miss[i] = 0; m_stale[i] = 0;
                m_h[i] = hc[i]; m_v[i] = vc[i]; m_d[i] = dm[i];
            end else if (m_live[i]) begin
                m_miss[i]  = m_miss[i] + 1;
                m_stale[i] = 1;
                if (m_miss[i] >= MM) m_live[i] = 0;
            end
`else
            m_live[i]  = vl[i];
            m_stale[i] = 0;
            if (vl[i]) begin
                m_h[i] = hc[i]; m_v[i] = vc[i]; m_d[i] = dm[i];
            end
`endif
            if (m_live[i]) lst.push_back(i);
        end
        if (lst.size() == 0) begin
            b = '{idx: 0, live: 0, stale: 0, last: 1, h: '0, v: '0, d: '0, t: first_t};
            exp_q.push_back(b);
        end else begin
            for (int j = 0; j < lst.size(); j++) begin
                b.idx   = lst[j];
                b.live  = 1;
                b.stale = m_stale[lst[j]];
                b.last  = (j == lst.size() - 1);
                b.h     = m_h[lst[j]];
                b.v     = m_v[lst[j]];
                b.d     = m_d[lst[j]];
                b.t     = (j == 0) ? first_t : -1;
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic set_slots(input int mask);
        for (int i = 0; i < NT; i++) begin
            vl[i] = mask[i];
            hc[i] = CW'($urandom_range(0, 2047));
            vc[i] = CW'($urandom_range(0, 2047));
            dm[i] = CW'($urandom_range(0, 2047));
        end
    endtask

    // One-cycle vsync; the model decides snapshot vs overrun from whether a report is outstanding.
    task automatic pulse_vsync();
        bit idle;
        idle = (exp_q.size() == 0);
        vsync_in  = 1'b1;
        exp_frame = (exp_frame + 1) & 16'hFFFF;
        if (idle) begin
            clr_q.push_back(cyc + 1);
            model_snapshot(cyc + 2);
        end else begin
            exp_ovr = 1;
        end
        step();
        vsync_in = 1'b0;
        check("frame_count", frame_count_out, exp_frame);
        check("overrun", overrun_out, exp_ovr);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL report_timeout: %0d beats outstanding, expected 0", exp_q.size());
            exp_q.delete();
            clr_q.delete();
        end
    endtask

    // Ready driver.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            case (rdy_mode)
                0:       rpt_ready_in = 1'b0;
                1:       rpt_ready_in = 1'b1;
                default: rpt_ready_in = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: compares det_clear timing and every presented beat against the queue head.
    initial begin
        bit    prev_cont = 0;
        bit    t_done    = 0;
        bit    exp_clr;
        beat_t b;
        forever begin
            @(negedge clk_in);
            if (!mon_en) begin
                prev_cont = 0;
                t_done    = 0;
            end else begin
                exp_clr = (clr_q.size() > 0 && clr_q[0] == cyc);
                if (exp_clr) void'(clr_q.pop_front());
                check("det_clear", det_clear_out, exp_clr);
                if (rpt_valid_out) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: valid=1 index=%0d, expected valid=0", rpt_index_out);
                    end else begin
                        b = exp_q[0];
                        if (b.t >= 0 && !t_done) begin
                            check("first_beat_cycle", cyc, b.t);
                            t_done = 1;
                        end
                        check("beat_index", rpt_index_out, b.idx);
                        check("beat_hcount", rpt_hcount_out, b.h);
                        check("beat_vcount", rpt_vcount_out, b.v);
                        check("beat_diameter", rpt_diameter_out, b.d);
                        check("beat_live", rpt_live_out, b.live);
                        check("beat_stale", rpt_stale_out, b.stale);
                        check("beat_last", rpt_last_out, b.last);
                        if (rpt_ready_in) begin
                            void'(exp_q.pop_front());
                            t_done = 0;
                        end
                    end
                end else if (prev_cont) begin
                    check("no_bubble_valid", rpt_valid_out, 1);
                end
                prev_cont = rpt_valid_out && rpt_ready_in && !rpt_last_out;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        int mask;
        for (int i = 0; i < NT; i++) begin
            hc[i] = '0; vc[i] = '0; dm[i] = '0; vl[i] = 1'b0;
        end
        model_reset();

        // Reset held with vsync and ready toggling.
        rdy_mode = 2;
        rst_n_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vsync_in = (c % 2 == 0);
            step();
            check("reset_outputs",
                  {det_clear_out, rpt_valid_out, rpt_index_out, rpt_hcount_out, rpt_vcount_out,
                   rpt_diameter_out, rpt_live_out, rpt_stale_out, rpt_last_out, overrun_out}, 0);
            check("reset_frame_count", frame_count_out, 0);
        end
        vsync_in = 1'b0;
        rst_n_in = 1'b1;
        rdy_mode = 1;
        step();
        mon_en = 1;
        step();

        // Slots 0 and 2 valid, consumer always ready.
        set_slots(4'b0101);
        hc[0] = 11'd100; vc[0] = 11'd200; dm[0] = 11'd12;
        hc[2] = 11'd640; vc[2] = 11'd512; dm[2] = 11'd30;
        pulse_vsync();
        wait_idle();
        repeat (2) step();

        // Same frame under backpressure: first beat held for several cycles.
        rdy_mode = 0;
        pulse_vsync();
        repeat (7) step();
        rdy_mode = 1;
        wait_idle();
        step();

        // Empty frame.
        set_slots(0);
        pulse_vsync();
        wait_idle();
        step();

        // vsync arriving mid-report.
        set_slots(4'b1011);
        rdy_mode = 0;
        pulse_vsync();
        repeat (3) step();
        set_slots(4'b0100);
        pulse_vsync();
        repeat (2) step();
        rdy_mode = 1;
        wait_idle();
        step();

        // Slot 1 seen once, then absent for several frames.
        set_slots(4'b0010);
        pulse_vsync();
        wait_idle();
        for (int f = 0; f < 4; f++) begin
            set_slots(0);
            pulse_vsync();
            wait_idle();
            step();
        end

        // Randomised frames, random ready, occasional extra vsync.
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            mask = $urandom_range(0, 15);
            set_slots(mask);
            pulse_vsync();
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(0, 4)) step();
                set_slots($urandom_range(0, 15));
                pulse_vsync();
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) step();
        end

        // Reset in the middle of a report withdraws valid.
        rdy_mode = 0;
        set_slots(4'b0101);
        pulse_vsync();
        repeat (2) step();
        mon_en   = 0;
        rst_n_in = 1'b0;
        step();
        check("reset_mid_valid", rpt_valid_out, 0);
        check("reset_mid_frame_count", frame_count_out, 0);
        check("reset_mid_overrun", overrun_out, 0);
        exp_q.delete();
        clr_q.delete();
        model_reset();
        rst_n_in = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
